// File: rtl/apb4_slave_ctrl.sv
// apb4_slave_ctrl
//   APB4 slave front end. Turns an APB transfer into a one-cycle registered
//   backend request (wr_en/rd_en plus latched addr/data/strobes) and waits for
//   a one-cycle backend acknowledge. It also enforces a minimum number of ACCESS
//   cycles (WAIT_STATES) and flags out-of-window or misaligned addresses with
//   PSLVERR.
//
//   Optional macro APB4_SLV_TIMEOUT_EN: when it is defined, an ACCESS phase
//   that sees no bk_ack for TIMEOUT cycles ends with an error completion. When
//   it is not defined, ACCESS waits for bk_ack with no limit.
//
// Ports
//   pclk, preset           clock and synchronous active-high reset
//   psel/penable/pwrite/
//   paddr/pwdata/pstrb     APB request
//   prdata/pready/pslverr  APB response; all three are zero outside DONE
//   wr_en/rd_en            one-cycle backend strobes (first ACCESS cycle)
//   addr/wr_data/wr_strb   latched offset, write data and write strobes
//   rd_data/bk_ack         backend read data and completion pulse
module apb4_slave_ctrl #(
  parameter int unsigned              DATA_WIDTH  = 32,
  parameter int unsigned              ADDR_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0]    BASE_ADDR   = '0,
  parameter logic [ADDR_WIDTH:0]      ADDR_SPACE  = 'd4096,
  parameter int unsigned              WAIT_STATES = 0,
  parameter int unsigned              TIMEOUT     = 16
) (
  input  logic                      pclk,
  input  logic                      preset,
  input  logic                      psel,
  input  logic                      penable,
  input  logic                      pwrite,
  input  logic [ADDR_WIDTH-1:0]     paddr,
  input  logic [DATA_WIDTH-1:0]     pwdata,
  input  logic [DATA_WIDTH/8-1:0]   pstrb,
  output logic [DATA_WIDTH-1:0]     prdata,
  output logic                      pready,
  output logic                      pslverr,
  output logic                      wr_en,
  output logic                      rd_en,
  output logic [ADDR_WIDTH-1:0]     addr,
  output logic [DATA_WIDTH-1:0]     wr_data,
  output logic [DATA_WIDTH/8-1:0]   wr_strb,
  input  logic [DATA_WIDTH-1:0]     rd_data,
  input  logic                      bk_ack
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;

  // Low address bits that must be zero for a word-aligned access. A mask
  // instead of a slice keeps DATA_WIDTH=8 (no alignment bits) legal.
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(STRB_W - 1);

  // Window bounds at ADDR_WIDTH+1 bits so BASE_ADDR+ADDR_SPACE cannot wrap.
  localparam logic [ADDR_WIDTH:0] WIN_LO = {1'b0, BASE_ADDR};
  localparam logic [ADDR_WIDTH:0] WIN_HI = {1'b0, BASE_ADDR} + ADDR_SPACE;

  localparam logic [7:0] WAIT_INIT = 8'(WAIT_STATES);

  // A zero or non-byte configuration has nothing sensible to build.
  if (TIMEOUT == 0 || (DATA_WIDTH % 8) != 0) begin : g_bad_cfg
  end

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t                  state_q,   state_d;
  logic                    write_q,   write_d;
  logic                    ack_seen_q, ack_seen_d;
  logic [7:0]              wcnt_q,    wcnt_d;
  logic [DATA_WIDTH-1:0]   rdata_q,   rdata_d;
  logic                    pready_q,  pready_d;
  logic                    pslverr_q, pslverr_d;
  logic [DATA_WIDTH-1:0]   prdata_q,  prdata_d;
  logic                    wr_en_q,   wr_en_d;
  logic                    rd_en_q,   rd_en_d;
  logic [ADDR_WIDTH-1:0]   addr_q,    addr_d;
  logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
  logic [STRB_W-1:0]       wr_strb_q, wr_strb_d;

`ifdef APB4_SLV_TIMEOUT_EN
  localparam int unsigned     TMO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  // Counter starts at 0 in the first ACCESS cycle, so the error completion is
  // scheduled in the cycle where the count has reached TIMEOUT-1.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  logic [TMO_W-1:0]           tmo_q, tmo_d;
`endif

  logic in_win;
  logic decode_err;

  assign in_win     = ({1'b0, paddr} >= WIN_LO) && ({1'b0, paddr} < WIN_HI);
  assign decode_err = !in_win || ((paddr & ALIGN_MASK) != '0);

  always_comb begin
    state_d    = state_q;
    write_d    = write_q;
    ack_seen_d = ack_seen_q;
    wcnt_d     = wcnt_q;
    rdata_d    = rdata_q;
    pready_d   = 1'b0;
    pslverr_d  = 1'b0;
    prdata_d   = '0;
    wr_en_d    = 1'b0;
    rd_en_d    = 1'b0;
    addr_d     = addr_q;
    wr_data_d  = wr_data_q;
    wr_strb_d  = wr_strb_q;
`ifdef APB4_SLV_TIMEOUT_EN
    tmo_d      = tmo_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (psel && !penable) begin
          write_d    = pwrite;
          addr_d     = paddr - BASE_ADDR;
          wr_data_d  = pwdata;
          wr_strb_d  = pwrite ? pstrb : '0;
          wcnt_d     = WAIT_INIT;
          ack_seen_d = 1'b0;
`ifdef APB4_SLV_TIMEOUT_EN
          tmo_d      = '0;
`endif
          if (decode_err) begin
            // Rejected without touching the backend.
            state_d   = DONE;
            pready_d  = 1'b1;
            pslverr_d = 1'b1;
          end else begin
            state_d = ACCESS;
            wr_en_d = pwrite;
            rd_en_d = !pwrite;
          end
        end
      end

      ACCESS: begin
        if (!psel) begin
          // Master abandoned the transfer: drop everything, no completion.
          state_d   = IDLE;
          addr_d    = '0;
          wr_data_d = '0;
          wr_strb_d = '0;
        end else begin
          // Only the first acknowledge of a transfer counts.
          if (bk_ack && !ack_seen_q) begin
            ack_seen_d = 1'b1;
            if (!write_q) rdata_d = rd_data;
          end
          if (wcnt_q != 8'd0) wcnt_d = wcnt_q - 8'd1;

          if (wcnt_q == 8'd0 && (ack_seen_q || bk_ack)) begin
            state_d  = DONE;
            pready_d = 1'b1;
            prdata_d = write_q ? '0 : rdata_d;
          end
`ifdef APB4_SLV_TIMEOUT_EN
          else if (!ack_seen_q && !bk_ack) begin
            if (tmo_q == TMO_LAST) begin
              state_d   = DONE;
              pready_d  = 1'b1;
              pslverr_d = 1'b1;
            end else begin
              tmo_d = tmo_q + TMO_W'(1);
            end
          end
`endif
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q    <= IDLE;
      write_q    <= 1'b0;
      ack_seen_q <= 1'b0;
      wcnt_q     <= '0;
      rdata_q    <= '0;
      pready_q   <= 1'b0;
      pslverr_q  <= 1'b0;
      prdata_q   <= '0;
      wr_en_q    <= 1'b0;
      rd_en_q    <= 1'b0;
      addr_q     <= '0;
      wr_data_q  <= '0;
      wr_strb_q  <= '0;
`ifdef APB4_SLV_TIMEOUT_EN
      tmo_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      write_q    <= write_d;
      ack_seen_q <= ack_seen_d;
      wcnt_q     <= wcnt_d;
      rdata_q    <= rdata_d;
      pready_q   <= pready_d;
      pslverr_q  <= pslverr_d;
      prdata_q   <= prdata_d;
      wr_en_q    <= wr_en_d;
      rd_en_q    <= rd_en_d;
      addr_q     <= addr_d;
      wr_data_q  <= wr_data_d;
      wr_strb_q  <= wr_strb_d;
`ifdef APB4_SLV_TIMEOUT_EN
      tmo_q      <= tmo_d;
`endif
    end
  end

  assign prdata  = prdata_q;
  assign pready  = pready_q;
  assign pslverr = pslverr_q;
  assign wr_en   = wr_en_q;
  assign rd_en   = rd_en_q;
  assign addr    = addr_q;
  assign wr_data = wr_data_q;
  assign wr_strb = wr_strb_q;

endmodule

// File: tb/tb_apb4_slave_ctrl.sv
// Bench for apb4_slave_ctrl: two instances share one APB bus, u_dut0 with
// WAIT_STATES=0 and u_dut3 with WAIT_STATES=3. Expected responses are queued
// when a transfer is launched and popped when the observed DUT raises pready.
module tb_apb4_slave_ctrl;

  logic        pclk = 1'b0;
  logic        preset;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata, rd_data;
  logic [3:0]  pstrb;
  logic        bk_ack;

  logic [31:0] p0_prdata, p3_prdata, p0_addr, p3_addr, p0_wr_data, p3_wr_data;
  logic        p0_pready, p3_pready, p0_pslverr, p3_pslverr;
  logic        p0_wr_en, p3_wr_en, p0_rd_en, p3_rd_en;
  logic [3:0]  p0_wr_strb, p3_wr_strb;

  always #5 pclk = ~pclk;

  apb4_slave_ctrl #(.WAIT_STATES(0), .TIMEOUT(16)) u_dut0 (
    .pclk(pclk), .preset(preset), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .prdata(p0_prdata),
    .pready(p0_pready), .pslverr(p0_pslverr), .wr_en(p0_wr_en), .rd_en(p0_rd_en),
    .addr(p0_addr), .wr_data(p0_wr_data), .wr_strb(p0_wr_strb),
    .rd_data(rd_data), .bk_ack(bk_ack));

  apb4_slave_ctrl #(.WAIT_STATES(3), .TIMEOUT(16)) u_dut3 (
    .pclk(pclk), .preset(preset), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .prdata(p3_prdata),
    .pready(p3_pready), .pslverr(p3_pslverr), .wr_en(p3_wr_en), .rd_en(p3_rd_en),
    .addr(p3_addr), .wr_data(p3_wr_data), .wr_strb(p3_wr_strb),
    .rd_data(rd_data), .bk_ack(bk_ack));

  // Observation mux: which instance the current transfer is checked against.
  logic        sel_ws;
  logic [31:0] o_prdata, o_addr, o_wr_data;
  logic        o_pready, o_pslverr, o_wr_en, o_rd_en;
  logic [3:0]  o_wr_strb;

  always_comb begin
    o_prdata  = sel_ws ? p3_prdata  : p0_prdata;
    o_pready  = sel_ws ? p3_pready  : p0_pready;
    o_pslverr = sel_ws ? p3_pslverr : p0_pslverr;
    o_wr_en   = sel_ws ? p3_wr_en   : p0_wr_en;
    o_rd_en   = sel_ws ? p3_rd_en   : p0_rd_en;
    o_addr    = sel_ws ? p3_addr    : p0_addr;
    o_wr_data = sel_ws ? p3_wr_data : p0_wr_data;
    o_wr_strb = sel_ws ? p3_wr_strb : p0_wr_strb;
  end

  typedef struct {
    logic        err;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic bus_idle(input int cycles);
    psel = 0; penable = 0; bk_ack = 0;
    for (int i = 0; i < cycles; i++) tick();
  endtask

  // One APB transfer. ack_at: ACCESS cycle index (1 = first) carrying bk_ack,
  // -1 for never. exp_lat: cycle index (setup = 0) at which pready must rise.
  task automatic run_xfer(input bit ws, input bit wr, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] st,
                          input int ack_at, input logic [31:0] rd,
                          input int exp_lat, input bit tmo_err, input string nm);
    exp_t e;
    bit   err;
    bit   done;
    int   t;
    sel_ws = ws;
    err    = (a >= 32'h1000) || (a[1:0] != 2'b00);
    e.err  = err || tmo_err;
    e.data = (!e.err && !wr) ? rd : 32'h0;
    exp_q.push_back(e);

    psel = 1; penable = 0; pwrite = wr; paddr = a; pwdata = wd; pstrb = st; bk_ack = 0;
    tick();
    t = 1; done = 0;
    while (!done) begin
      penable = 1;
      n_tests++;
      if (o_wr_en !== (!err && wr && t == 1) || o_rd_en !== (!err && !wr && t == 1)) begin
        n_fail++;
        $display("FAIL %s strobes t=%0d: wr_en=%b rd_en=%b", nm, t, o_wr_en, o_rd_en);
      end
      if (t == 1 && !err) begin
        n_tests++;
        if (o_addr !== a || o_wr_data !== wd || o_wr_strb !== (wr ? st : 4'h0)) begin
          n_fail++;
          $display("FAIL %s latch: addr=%h/%h wr_data=%h/%h wr_strb=%b/%b", nm,
                   o_addr, a, o_wr_data, wd, o_wr_strb, wr ? st : 4'h0);
        end
      end
      if (o_pready) begin
        n_tests++;
        if (t != exp_lat) begin
          n_fail++;
          $display("FAIL %s latency: pready at T%0d, want T%0d", nm, t, exp_lat);
        end
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL %s scoreboard: pready with empty queue", nm);
        end else begin
          e = exp_q.pop_front();
          if (o_pslverr !== e.err || o_prdata !== e.data) begin
            n_fail++;
            $display("FAIL %s response: pslverr=%b prdata=%h, want %b %h", nm,
                     o_pslverr, o_prdata, e.err, e.data);
          end
        end
        done = 1; bk_ack = 0;
      end else begin
        n_tests++;
        if (o_pslverr !== 1'b0 || o_prdata !== 32'h0) begin
          n_fail++;
          $display("FAIL %s early resp t=%0d: pslverr=%b prdata=%h", nm, t, o_pslverr, o_prdata);
        end
        if (t >= 150) begin
          n_fail++;
          $display("FAIL %s timeout: no pready after %0d cycles, want T%0d", nm, t, exp_lat);
          void'(exp_q.pop_back());
          done = 1; bk_ack = 0; psel = 0; penable = 0;
        end else begin
          bk_ack  = (t == ack_at);
          rd_data = (t == ack_at) ? rd : (32'hBAD0_0000 | 32'(t));
        end
      end
      tick();
      t++;
    end
    n_tests++;
    if (o_pready !== 1'b0 || o_pslverr !== 1'b0 || o_prdata !== 32'h0) begin
      n_fail++;
      $display("FAIL %s after DONE: pready=%b pslverr=%b prdata=%h, want 0 0 0", nm,
               o_pready, o_pslverr, o_prdata);
    end
  endtask

  task automatic test_reset();
    preset = 1; psel = 0; penable = 0; pwrite = 0; paddr = 0; pwdata = 0;
    pstrb = 0; bk_ack = 0; rd_data = 0;
    tick(); tick();
    n_tests++;
    if ({p0_pready, p0_pslverr, p0_wr_en, p0_rd_en, p3_pready, p3_wr_en, p3_rd_en} !== 7'b0 ||
        p0_prdata !== 0 || p0_addr !== 0 || p0_wr_data !== 0 || p0_wr_strb !== 0) begin
      n_fail++;
      $display("FAIL reset: pready=%b pslverr=%b prdata=%h addr=%h, want all 0",
               p0_pready, p0_pslverr, p0_prdata, p0_addr);
    end
    preset = 0;
    tick();
  endtask

  task automatic test_read();
    run_xfer(0, 0, 32'h10, 32'h0, 4'h0, 1, 32'hDEADBEEF, 2, 0, "read_0x10");
    bus_idle(1);
    run_xfer(0, 0, 32'hFFC, 32'h0, 4'h0, 1, 32'hA5A5_0FFC, 2, 0, "read_top_word");
    bus_idle(1);
  endtask

  task automatic test_write();
    run_xfer(0, 1, 32'h20, 32'hCAFE_F00D, 4'b1111, 1, 32'h0, 2, 0, "write_full");
    bus_idle(1);
    run_xfer(0, 1, 32'h24, 32'h0BAD_BEEF, 4'b0000, 1, 32'h0, 2, 0, "write_strb0");
    bus_idle(2);
  endtask

  task automatic test_wait_states();
    // u_dut3 must start from IDLE; the idle cycles above abort its leftovers.
    run_xfer(1, 1, 32'h4, 32'h12345678, 4'b0101, 1, 32'h0, 5, 0, "ws3_write");
    bus_idle(1);
    run_xfer(1, 0, 32'h8, 32'h0, 4'h0, 4, 32'h1357_9BDF, 5, 0, "ws3_read_late_ack");
    bus_idle(1);
    run_xfer(1, 0, 32'hC, 32'h0, 4'h0, 6, 32'h2468_ACE0, 7, 0, "ws3_read_after_wait");
    bus_idle(2);
  endtask

  task automatic test_decode_err();
    run_xfer(0, 0, 32'h1000, 32'h0, 4'h0, -1, 32'h0, 1, 0, "err_out_of_window");
    bus_idle(1);
    run_xfer(0, 0, 32'h6, 32'h0, 4'h0, -1, 32'h0, 1, 0, "err_misaligned");
    bus_idle(1);
    run_xfer(0, 1, 32'hFFFF_FFFC, 32'h1, 4'hF, -1, 32'h0, 1, 0, "err_top_of_space");
    bus_idle(1);
  endtask

  task automatic test_back_to_back();
    run_xfer(0, 0, 32'h0, 32'h0, 4'h0, 1, 32'h1111_0000, 2, 0, "b2b_first");
    run_xfer(0, 0, 32'h8, 32'h0, 4'h0, 1, 32'h2222_0008, 2, 0, "b2b_second");
    run_xfer(0, 1, 32'hC, 32'h5555_AAAA, 4'b1001, 1, 32'h0, 2, 0, "b2b_third");
    bus_idle(2);
  endtask

  task automatic test_abort();
    // Reset in ACCESS.
    sel_ws = 0;
    psel = 1; penable = 0; pwrite = 0; paddr = 32'h30; bk_ack = 0;
    tick();
    penable = 1; preset = 1;
    tick();
    preset = 0; psel = 0; penable = 0;
    n_tests++;
    if (p0_pready !== 0 || p0_rd_en !== 0 || p0_addr !== 0 || p0_prdata !== 0) begin
      n_fail++;
      $display("FAIL abort_reset: pready=%b rd_en=%b addr=%h prdata=%h, want 0",
               p0_pready, p0_rd_en, p0_addr, p0_prdata);
    end
    bk_ack = 1; rd_data = 32'hFEED_0001;
    tick();
    bk_ack = 0;
    tick();
    n_tests++;
    if (p0_pready !== 0) begin
      n_fail++;
      $display("FAIL abort_reset late_ack: pready=%b, want 0", p0_pready);
    end
    run_xfer(0, 0, 32'h34, 32'h0, 4'h0, 1, 32'h7777_0034, 2, 0, "after_reset_abort");
    bus_idle(1);

    // psel dropped in ACCESS.
    psel = 1; penable = 0; pwrite = 1; paddr = 32'h38; pwdata = 32'h99; pstrb = 4'hF;
    tick();
    psel = 0; penable = 0;
    tick();
    n_tests++;
    if (p0_pready !== 0 || p0_wr_en !== 0 || p0_addr !== 0 || p0_wr_data !== 0 ||
        p0_wr_strb !== 0 || p0_pslverr !== 0) begin
      n_fail++;
      $display("FAIL abort_psel: pready=%b wr_en=%b addr=%h wr_data=%h wr_strb=%b, want 0",
               p0_pready, p0_wr_en, p0_addr, p0_wr_data, p0_wr_strb);
    end
    bk_ack = 1;
    tick();
    bk_ack = 0;
    tick();
    n_tests++;
    if (p0_pready !== 0) begin
      n_fail++;
      $display("FAIL abort_psel late_ack: pready=%b, want 0", p0_pready);
    end
    run_xfer(0, 0, 32'h3C, 32'h0, 4'h0, 1, 32'h8888_003C, 2, 0, "after_psel_abort");
    bus_idle(2);
  endtask

  task automatic test_no_ack();
`ifdef APB4_SLV_TIMEOUT_EN
    run_xfer(0, 0, 32'h40, 32'h0, 4'h0, -1, 32'h0, 17, 1, "timeout_read");
    bus_idle(2);
`else
    int seen;
    sel_ws = 0; seen = 0;
    psel = 1; penable = 0; pwrite = 0; paddr = 32'h40; bk_ack = 0;
    tick();
    penable = 1;
    for (int i = 0; i < 100; i++) begin
      if (p0_pready !== 1'b0) seen++;
      tick();
    end
    n_tests++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL no_ack_wait: pready high in %0d of 100 cycles, want 0", seen);
    end
    bus_idle(2);
    run_xfer(0, 0, 32'h44, 32'h0, 4'h0, 1, 32'h4444_0044, 2, 0, "after_no_ack");
    bus_idle(1);
`endif
  endtask

  initial begin
    sel_ws = 0;
    test_reset();
    test_read();
    test_write();
    test_wait_states();
    test_decode_err();
    test_back_to_back();
    test_abort();
    test_no_ack();
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within 200000 time units");
    $fatal(1);
  end

endmodule

// File: doc/apb4_slave_ctrl.md
Name: apb4_slave_ctrl

Overview:
- APB4 slave front end that converts APB transfers into a registered, single-cycle local backend request and waits for a backend acknowledge.
- Sits between the APB interconnect and a register bank or memory.
- Generalises the previous slave with:
  - byte strobes
  - a programmable minimum wait count
  - address-range and alignment checking with PSLVERR
  - an optional backend timeout

Parameters:
- DATA_WIDTH, 32, data bus width; must be a multiple of 8.
- ADDR_WIDTH, 32, address bus width.
- BASE_ADDR, 0, first byte address decoded by this slave.
- ADDR_SPACE, 4096, decoded window size in bytes; valid range is BASE_ADDR to BASE_ADDR+ADDR_SPACE-1.
- WAIT_STATES, 0, minimum number of ACCESS cycles before completion is allowed (0–255).
- TIMEOUT, 16, number of ACCESS cycles without bk_ack before an error completion; used only with the optional feature.

Ports:
- pclk in 1: clock, rising edge.
- preset in 1: synchronous reset, active-high.
- psel in 1: APB select.
- penable in 1: APB enable.
- pwrite in 1: 1 = write, 0 = read.
- paddr in ADDR_WIDTH: byte address.
- pwdata in DATA_WIDTH: write data.
- pstrb in DATA_WIDTH/8: write byte strobes.
- prdata out DATA_WIDTH: read data; valid only while pready=1.
- pready out 1: transfer complete.
- pslverr out 1: error response; qualified by pready.
- wr_en out 1: one-cycle backend write request.
- rd_en out 1: one-cycle backend read request.
- addr out ADDR_WIDTH: latched offset (paddr - BASE_ADDR).
- wr_data out DATA_WIDTH: latched pwdata.
- wr_strb out DATA_WIDTH/8: latched pstrb on writes; 0 on reads.
- rd_data in DATA_WIDTH: backend read data; sampled when bk_ack=1.
- bk_ack in 1: backend completion, one cycle.

Behaviour:
- Reset:
  - preset=1 at a clock edge forces state IDLE and zeroes all outputs, counters, the ack_seen flag and the read data register.
  - Reset wins over any in-flight transfer; the transfer is abandoned with no pready.
- All outputs are registered (flop outputs, no combinational input-to-output paths).
- FSM states are IDLE, ACCESS and DONE.
- IDLE:
  - The setup phase is psel=1, penable=0.
  - On a setup phase, latch pwrite, addr, wr_data and wr_strb.
  - Decode: error if paddr is outside the window, or paddr[log2(DATA_WIDTH/8)-1:0] is non-zero.
  - Error case: go to DONE with pslverr=1. No wr_en/rd_en. WAIT_STATES is not applied.
  - Valid case: go to ACCESS and assert exactly one of wr_en/rd_en for the first ACCESS cycle only.
  - Load the wait counter with WAIT_STATES and clear ack_seen.
- ACCESS:
  - bk_ack=1 sets ack_seen; on a read it also captures rd_data.
  - The wait counter decrements to 0 and holds there.
  - When counter==0 and (ack_seen or bk_ack this cycle), go to DONE with pslverr=0.
  - A second bk_ack within the same transfer is ignored.
- DONE:
  - pready=1 for exactly one cycle; prdata = captured data for an error-free read, otherwise 0.
  - Next state is IDLE. A back-to-back setup phase presented in the cycle after pready is accepted from IDLE without loss.
- Latency with WAIT_STATES=0 and bk_ack in the first ACCESS cycle: setup at T0, strobe at T1, pready at T2.
- In general, pready is asserted one cycle after the later of (WAIT_STATES elapsed, bk_ack seen).
- Protocol violation: psel=0 while in ACCESS → return to IDLE immediately, no pready, late bk_ack ignored.
- bk_ack while in IDLE or DONE is ignored.
- A write with pstrb=0 still issues wr_en, with wr_strb=0.
- pready, pslverr and prdata are 0 in every cycle other than DONE.
- Window arithmetic:
  - Compare at ADDR_WIDTH+1 bits so that BASE_ADDR+ADDR_SPACE does not wrap.
  - The top byte of the window is valid; the next aligned word is an error.

Optional Feature:
- Macro: APB4_SLV_TIMEOUT_EN.
- Defined:
  - A timeout counter clears on ACCESS entry and increments each ACCESS cycle without ack_seen.
  - On reaching TIMEOUT, go to DONE with pslverr=1 and prdata=0.
  - This fires even if the wait counter is non-zero.
- Not defined:
  - No timeout logic is present; ACCESS waits indefinitely for bk_ack.
  - The TIMEOUT parameter is unused.

Test Plan:
- Reset, then read paddr=0x10 with WAIT_STATES=0 and bk_ack at T1 with rd_data=0xDEADBEEF → rd_en=1 at T1 only, addr=0x10; pready=1, pslverr=0 and prdata=0xDEADBEEF at T2.
- WAIT_STATES=3, write paddr=0x4, pwdata=0x12345678, pstrb=4'b0101, bk_ack at T1 → wr_en=1 at T1, wr_data=0x12345678, wr_strb=0101; pready=1 at T5 (T1+3 wait cycles+1), pslverr=0.
- Read paddr=0x1000 (just outside the window), then paddr=0x6 (misaligned) → no rd_en, pready=1 and pslverr=1 at T1, prdata=0 for both.
- Two back-to-back reads to 0x0 and 0x8 with bk_ack each time → two pready pulses, correct data each; the second setup phase is accepted in the cycle after the first pready.
- APB4_SLV_TIMEOUT_EN defined with TIMEOUT=16, read with bk_ack never asserted → pready=1, pslverr=1 at T17, prdata=0; without the macro, pready stays 0 for 100 cycles.
- Mid-transfer: assert preset in ACCESS, or drop psel in ACCESS → IDLE next cycle, all outputs 0, no pready; a subsequent read completes normally.
